// File: rtl/morse_pkg.sv
// Shared Morse symbol constants and state encoding for the encoder and decoder paths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_ESPACE,
    ST_LGAP,
    ST_WGAP
  } morse_state_t;

  // Durations in Morse units
  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int ELEM_GAP_UNITS   = 1;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS   = 7;

  // Longest symbol carried by the 5-bit pattern
  localparam int MAX_ELEMENTS = 5;

  // Counts of 6 and 7 cannot be represented by the pattern, so they saturate.
  function automatic logic [2:0] clamp_count(input logic [2:0] cnt);
    return (cnt > 3'(MAX_ELEMENTS)) ? 3'(MAX_ELEMENTS) : cnt;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter timing an interval of 1..7 Morse units.
// Latency: interval starts the cycle after load; last is high on its final cycle.
// Backpressure: none; reload on load at any time, holds at zero when expired.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] units,
  output logic       last,
  output logic       expire
);

  localparam int CNT_RAW = $clog2(WORD_GAP_UNITS * UNIT_CYCLES);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  // Count of cycles remaining after the first one of the interval
  assign load_val = CNT_W'(int'(units) * UNIT_CYCLES - 1);

  // Reload on every state entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // last marks the final cycle; expire is one cycle earlier so that a
  // registered output can line up exactly with the final cycle.
  assign last   = (cnt == '0);
  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/morse_encoder_tx.sv
// Morse keyer: one letter per valid/ready handshake, keyed output with unit timing; optional sidetone via MORSE_TX_SIDETONE_EN.
// Latency: key rises the cycle after acceptance; done pulses on the final trailing-gap cycle.
// Backpressure: ready only in IDLE or on the final gap cycle; valid otherwise ignored, no queuing.
module morse_encoder_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 5_000_000,
  parameter int TONE_HALF_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] symbol,
  input  logic [2:0] symbol_count,
  input  logic       word_end,
  input  logic       valid,
  output logic       ready,
  output logic       key,
  output logic       dash_active,
  output logic       done,
  output logic       tone
);

  if (UNIT_CYCLES < 1 || TONE_HALF_CYCLES < 1) begin : g_bad_param
    $error("morse_encoder_tx: UNIT_CYCLES and TONE_HALF_CYCLES must be >= 1");
  end

  morse_state_t state, nxt_state, st_state, gap_state;
  logic [4:0]   sym_q;
  logic [2:0]   idx_q, nxt_idx;
  logic         wend_q;
  logic         nxt_dash;
  logic         tmr_load, tmr_last, tmr_expire;
  logic [2:0]   tmr_units;
  logic [2:0]   cnt_c, st_idx, st_units, gap_units;
  logic         st_dash, in_gap, accept;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .units (tmr_units),
    .last  (tmr_last),
    .expire(tmr_expire)
  );

  // Where a freshly accepted letter starts (read straight from the inputs)
  assign cnt_c    = clamp_count(symbol_count);
  assign st_idx   = cnt_c - 3'd1;
  assign st_dash  = (cnt_c != 3'd0) && symbol[st_idx];
  assign st_state = (cnt_c != 3'd0) ? ST_MARK : (word_end ? ST_WGAP : ST_LGAP);
  assign st_units = (cnt_c != 3'd0) ? (st_dash ? 3'(DASH_UNITS) : 3'(DOT_UNITS))
                                    : (word_end ? 3'(WORD_GAP_UNITS) : 3'(LETTER_GAP_UNITS));

  // Trailing gap of the letter in flight
  assign gap_state = wend_q ? ST_WGAP : ST_LGAP;
  assign gap_units = wend_q ? 3'(WORD_GAP_UNITS) : 3'(LETTER_GAP_UNITS);

  assign in_gap = (state == ST_LGAP) || (state == ST_WGAP);
  assign ready  = (state == ST_IDLE) || (in_gap && tmr_last);
  assign accept = valid && ready;

  // Next state, element index and timer reload for the coming cycle
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx_q;
    nxt_dash  = 1'b0;
    tmr_load  = 1'b0;
    tmr_units = 3'(DOT_UNITS);
    case (state)
      ST_IDLE: ;
      ST_MARK: begin
        if (tmr_last) begin
          tmr_load = 1'b1;
          if (idx_q != 3'd0) begin
            nxt_state = ST_ESPACE;
            tmr_units = 3'(ELEM_GAP_UNITS);
          end else begin
            nxt_state = gap_state;
            tmr_units = gap_units;
          end
        end else begin
          nxt_dash = sym_q[idx_q];
        end
      end
      ST_ESPACE: begin
        if (tmr_last) begin
          nxt_state = ST_MARK;
          nxt_idx   = idx_q - 3'd1;
          nxt_dash  = sym_q[idx_q - 3'd1];
          tmr_load  = 1'b1;
          tmr_units = sym_q[idx_q - 3'd1] ? 3'(DASH_UNITS) : 3'(DOT_UNITS);
        end
      end
      ST_LGAP, ST_WGAP: begin
        if (tmr_last) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
    // Acceptance on the final gap cycle chains straight into the next letter
    if (accept) begin
      nxt_state = st_state;
      nxt_idx   = st_idx;
      nxt_dash  = st_dash;
      tmr_load  = 1'b1;
      tmr_units = st_units;
    end
  end

  // FSM state, latched letter fields and registered key/dash/done outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx_q       <= 3'd0;
      sym_q       <= 5'd0;
      wend_q      <= 1'b0;
      key         <= 1'b0;
      dash_active <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt_state;
      idx_q       <= nxt_idx;
      if (accept) begin
        sym_q  <= symbol;
        wend_q <= word_end;
      end
      key         <= (nxt_state == ST_MARK);
      dash_active <= nxt_dash;
      // Gaps last at least three cycles, so the penultimate cycle is always in the gap
      done        <= in_gap && tmr_expire;
    end
  end

`ifdef MORSE_TX_SIDETONE_EN
  localparam int TONE_W = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

  logic [TONE_W-1:0] tone_cnt;
  logic              tone_q;

  // Square wave while keyed; phase restarts from low at every key rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (!key) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (tone_cnt == TONE_W'(TONE_HALF_CYCLES - 1)) begin
      tone_cnt <= '0;
      tone_q   <= ~tone_q;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign tone = tone_q & key;
`else
  assign tone = 1'b0;
`endif

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Self-checking bench for morse_encoder_tx with UNIT_CYCLES=4.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_morse_encoder_tx;

  localparam int U    = 4;
  localparam int HALF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] symbol;
  logic [2:0] symbol_count;
  logic       word_end;
  logic       valid;
  logic       ready, key, dash_active, done, tone;

  always #5 clk = ~clk;

  morse_encoder_tx #(
    .UNIT_CYCLES(U),
    .TONE_HALF_CYCLES(HALF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .symbol      (symbol),
    .symbol_count(symbol_count),
    .word_end    (word_end),
    .valid       (valid),
    .ready       (ready),
    .key         (key),
    .dash_active (dash_active),
    .done        (done),
    .tone        (tone)
  );

  // Expected per-cycle outputs; q[0] is the cycle currently on the wires
  typedef struct {
    bit key;
    bit dash;
    bit done;
    int pos;
  } ent_t;
  ent_t q[$];

  int checks = 0;
  int errors = 0;
  bit s_key, s_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expand one letter into its cycle-by-cycle waveform
  function automatic void push_letter(input logic [4:0] s, input logic [2:0] c, input logic w);
    int   n;
    int   gap;
    int   len;
    ent_t e;
    n = (c > 5) ? 5 : int'(c);
    for (int i = n - 1; i >= 0; i--) begin
      len = (s[i] ? 3 : 1) * U;
      for (int j = 0; j < len; j++) begin
        e.key = 1; e.dash = s[i]; e.done = 0; e.pos = j;
        q.push_back(e);
      end
      if (i > 0) begin
        for (int j = 0; j < U; j++) begin
          e.key = 0; e.dash = 0; e.done = 0; e.pos = 0;
          q.push_back(e);
        end
      end
    end
    gap = (w ? 7 : 3) * U;
    for (int j = 0; j < gap; j++) begin
      e.key = 0; e.dash = 0; e.done = (j == gap - 1); e.pos = 0;
      q.push_back(e);
    end
  endfunction

  // One cycle: check this cycle's outputs, then drive inputs sampled at its closing edge
  task automatic step(input logic v, input logic [4:0] s, input logic [2:0] c, input logic w);
    ent_t e;
    bit   rdy_m;
    int   exp_tone;
    @(negedge clk);
    if (q.size() > 0) e = q[0];
    else begin e.key = 0; e.dash = 0; e.done = 0; e.pos = 0; end
    rdy_m = (q.size() <= 1);
    chk("key", int'(key), int'(e.key));
    chk("dash_active", int'(dash_active), int'(e.dash));
    chk("done", int'(done), int'(e.done));
    chk("ready", int'(ready), int'(rdy_m));
`ifdef MORSE_TX_SIDETONE_EN
    exp_tone = (e.key && ((e.pos / HALF) % 2 == 1)) ? 1 : 0;
`else
    exp_tone = 0;
`endif
    chk("tone", int'(tone), exp_tone);
    s_key  = key;
    s_done = done;
    valid        = v;
    symbol       = s;
    symbol_count = c;
    word_end     = w;
    if (q.size() > 0) void'(q.pop_front());
    if (v && rdy_m) push_letter(s, c, w);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 300) begin
      step(1'b0, 5'd0, 3'd0, 1'b0);
      guard++;
    end
    chk("drain_bounded", int'(q.size()), 0);
  endtask

  typedef struct {
    logic [4:0] sym;
    logic [2:0] cnt;
    logic       w;
    int         done_cyc;
    int         high;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   dc, high;
    bit   kv[64];
    int   r1, r2, f1;

    vt[0] = '{5'b00001, 3'd2, 1'b0, 32, 16};  // A
    vt[1] = '{5'b00000, 3'd1, 1'b1, 32,  4};  // E + word gap
    vt[2] = '{5'b00000, 3'd0, 1'b1, 28,  0};  // bare word gap
    vt[3] = '{5'b00000, 3'd0, 1'b0, 12,  0};  // bare letter gap
    vt[4] = '{5'b11111, 3'd7, 1'b0, 88, 60};  // clamped to five dashes

    reset = 1'b1; valid = 1'b0; symbol = '0; symbol_count = '0; word_end = 1'b0;
    #12;
    chk("rst_ready", int'(ready), 1);
    chk("rst_key", int'(key), 0);
    chk("rst_dash", int'(dash_active), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tone", int'(tone), 0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 5'd0, 3'd0, 1'b0);

    // Table-driven single letters from IDLE
    for (int t = 0; t < 5; t++) begin
      dc = -1; high = 0;
      step(1'b1, vt[t].sym, vt[t].cnt, vt[t].w);
      for (int k = 1; k < 200; k++) begin
        step(1'b0, 5'd0, 3'd0, 1'b0);
        if (s_key) high++;
        if (s_done) begin dc = k; break; end
      end
      chk($sformatf("vec%0d_done_cycle", t), dc, vt[t].done_cyc);
      chk($sformatf("vec%0d_key_high", t), high, vt[t].high);
      drain();
    end

    // Two T letters back to back with valid held high
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 5'b00001, 3'd1, 1'b0);
      kv[k] = s_key;
    end
    r1 = -1; r2 = -1; f1 = -1;
    for (int k = 1; k < 40; k++) begin
      if (kv[k] && !kv[k-1]) begin
        if (r1 < 0) r1 = k; else if (r2 < 0) r2 = k;
      end
      if (!kv[k] && kv[k-1] && f1 < 0) f1 = k;
    end
    chk("tt_first_rise", r1, 1);
    chk("tt_second_rise", r2, 25);
    chk("tt_low_gap", r2 - f1, 12);
    drain();

    // Reset in the middle of a dash, then a clean E
    step(1'b1, 5'b00001, 3'd1, 1'b0);
    for (int k = 1; k < 10; k++) step(1'b0, 5'd0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_key", int'(key), 1);
    reset = 1'b1;
    #1;
    chk("async_key", int'(key), 0);
    chk("async_dash", int'(dash_active), 0);
    chk("async_done", int'(done), 0);
    chk("async_tone", int'(tone), 0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 5'd0, 3'd0, 1'b0);
    step(1'b1, 5'b00000, 3'd1, 1'b0);
    drain();

    // Random traffic against the waveform model
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 3) != 0), 5'($urandom), 3'($urandom), 1'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_encoder_tx.md
# morse_encoder_tx

Morse transmitter: accepts one letter per valid/ready handshake as a 5-bit element pattern plus element count. It emits a keyed on/off output with standard unit timing: dot 1, dash 3, element gap 1, letter gap 3, word gap 7 units. It is the send-side counterpart of the decoder path and shares its symbol format (1 = dash, 0 = dot, up to 5 elements). It sits between the character source and the key/LED/sidetone output.

## Interface
- UNIT_CYCLES, 5_000_000, clock cycles per Morse unit (≥1; 50 ms at 100 MHz)
- TONE_HALF_CYCLES, 50_000, sidetone half-period in cycles (used only with MORSE_TX_SIDETONE_EN)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- symbol  in  5  element pattern; symbol[count-1] sent first, symbol[0] last; 1 = dash
- symbol_count  in  3  number of elements, 0..5; 6 and 7 are clamped to 5
- word_end  in  1  1 = follow the letter with a word gap (7 units) instead of a letter gap (3 units)
- valid  in  1  symbol/symbol_count/word_end are valid
- ready  out  1  block accepts on valid&ready
- key  out  1  Morse keying, 1 = mark
- dash_active  out  1  current mark is a dash (qualifies key)
- done  out  1  one-cycle pulse on the final cycle of the trailing gap
- tone  out  1  sidetone square wave gated by key

## Operation
- States: IDLE, MARK, ESPACE (element gap), LGAP, WGAP.
- IDLE: ready=1, key=0. On valid&ready, latch the pattern, the clamped count and word_end.
  - Count>0: go to MARK with the element index at count-1.
  - Count=0: go to WGAP if word_end, else LGAP.
- MARK: key=1 for 1×UNIT_CYCLES (dot) or 3×UNIT_CYCLES (dash). Then:
  - If elements remain, go to ESPACE.
  - Otherwise go to WGAP or LGAP, selected by word_end.
- ESPACE: key=0 for UNIT_CYCLES, decrement the index, return to MARK.
- LGAP/WGAP: key=0 for 3×/7×UNIT_CYCLES.
  - On the final cycle: done=1 and ready=1.
  - An acceptance on that cycle goes straight to MARK (or to the next gap state), so the back-to-back spacing stays exact.
  - With no acceptance, go to IDLE.
- ready is 0 in MARK, ESPACE and all non-final gap cycles. valid while not ready is ignored, with no queuing.
- Input fields are sampled only at acceptance. Later changes have no effect.
- The single cycle counter reloads on every state entry. Width is $clog2(7*UNIT_CYCLES).
- Reset mid-operation: key, dash_active, done and tone go to 0 immediately (async). State becomes IDLE. The in-flight symbol is discarded.
- Reset values: state IDLE, ready=1, key=0, dash_active=0, done=0, tone=0.

## Timing
- Acceptance at cycle 0 from IDLE: key rises at cycle 1.
- Acceptance on a final gap cycle: key rises on the next cycle.
- Mark and space durations are exact multiples of UNIT_CYCLES, with no extra cycles at transitions.
- key, dash_active and done are registered outputs. ready is combinational from state and counter.

## Configuration
- MORSE_TX_SIDETONE_EN
  - Defined: tone toggles every TONE_HALF_CYCLES while key=1. Its phase counter restarts at each key rise, and tone is forced to 0 when key=0.
  - Undefined: the tone port remains and is tied to 0. No tone counter is synthesized.

## Structure
- Shared package morse_pkg holds:
  - the state enum;
  - DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7;
  - MAX_ELEMENTS=5.
  - The decoder side reuses the same constants.
- One sub-module: morse_unit_timer.
  - Loadable down-counter with inputs load and units (1..7).
  - Outputs last (final cycle) and expire.
  - Parameterized by UNIT_CYCLES.
- The optional tone generator is inline.

## Test plan
(UNIT_CYCLES=4 throughout)
- 'A': symbol=5'b00001, count=2, word_end=0, accepted at cycle 0 -> key high 1–4, low 5–8, high 9–20 with dash_active=1, low 21–32; done and ready at 32.
- 'E' + word: symbol=0, count=1, word_end=1 -> key high 1–4, low 5–32; done at 32.
- count=0, word_end=1 -> key stays low; done at cycle 28. count=0, word_end=0 -> done at cycle 12.
- count=7, symbol=5'b11111 -> exactly five dashes (5×12 high, 4×4 element gaps, 12 trailing); done at cycle 88.
- Two 'T' back-to-back with valid held high -> the second is accepted on the done cycle; key low exactly 12 cycles between marks; valid during marks is not accepted.
- reset pulsed at cycle 10 of a dash -> key=0 asynchronously, ready=1 after release, next 'E' sent correctly. With MORSE_TX_SIDETONE_EN and TONE_HALF_CYCLES=2: tone toggles every 2 cycles only while key=1.
